// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-add multiplier, one partial-product
// bit per clock. An operand pair is accepted through valid_in/src_ready,
// WIDTH iterations run, and the 2*WIDTH-bit product is held with valid_out
// until dest_ready.
// Optional feature macro: MUL_SIGNED_EN (two's complement operands/product).
module shift_add_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 src_ready,
    output logic                 valid_out,
    input  logic                 dest_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_q, a_d;
    logic [PW-1:0]   p_q, p_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Operand values loaded into A/B at acceptance.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // Running sum for the current iteration.
    logic [PW-1:0]   p_sum;
    logic            last_iter;

    assign p_sum     = p_q + (b_q[0] ? a_q : '0);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

`ifdef MUL_SIGNED_EN
    logic sign_q, sign_d;

    // Magnitudes: the most negative value maps to 2^(WIDTH-1), which still
    // fits as an unsigned WIDTH-bit number.
    assign op_a = multiplicand[WIDTH-1] ? ((~multiplicand) + WIDTH'(1)) : multiplicand;
    assign op_b = multiplier[WIDTH-1]   ? ((~multiplier) + WIDTH'(1))   : multiplier;
`else
    assign op_a = multiplicand;
    assign op_b = multiplier;
`endif

    // Handshake flags are plain decodes of the registered state.
    assign src_ready = (state_q == IDLE);
    assign valid_out = (state_q == DONE);
    assign product   = p_q;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
`ifdef MUL_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
`ifdef MUL_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    // Next-state and datapath update: load in IDLE, iterate in BUSY, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
`ifdef MUL_SIGNED_EN
        sign_d  = sign_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    a_d     = {{WIDTH{1'b0}}, op_a};
                    b_d     = op_b;
                    p_d     = '0;
                    cnt_d   = '0;
`ifdef MUL_SIGNED_EN
                    sign_d  = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                p_d   = p_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
`ifdef MUL_SIGNED_EN
                    // Sign is applied on the final iteration so latency is unchanged.
                    if (sign_q) begin
                        p_d = (~p_sum) + PW'(1);
                    end
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                // P is not touched here, so product cannot change while valid_out is high.
                if (dest_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: a cycle-level model of the handshake with an
// arithmetic reference product, checked every cycle, plus directed vectors
// with hand-computed products and latencies.
module tb_shift_add_multiplier;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           valid_in = 1'b0;
    logic           dest_ready = 1'b0;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic           src_ready;
    logic           valid_out;
    logic [2*W-1:0] product;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .src_ready    (src_ready),
        .valid_out    (valid_out),
        .dest_ready   (dest_ready),
        .product      (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference product straight from arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_SIGNED_EN
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
    endfunction

    // Behavioural model: idle -> (W edges of work) -> done -> idle on dest_ready.
    bit             m_idle = 1'b1;
    bit             m_done = 1'b0;
    int             m_wait = 0;
    logic [2*W-1:0] m_prod = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_wait <= 0;
        end else if (m_idle) begin
            if (valid_in) begin
                m_prod <= ref_mul(mcand, mplier);
                m_idle <= 1'b0;
                m_wait <= W;
            end
        end else if (!m_done) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_done <= 1'b1;
        end else if (dest_ready) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (reset) begin
            chk("src_ready", src_ready, m_idle);
            chk("valid_out", valid_out, m_done);
            if (m_done) chk("product", product, m_prod);
        end
    end

    // One directed transaction: latency, literal product, hold, completion.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp, input int hold, input bit pulse);
        int n;
        @(negedge clk);
        chk("idle_before", src_ready, 1'b1);
        mcand = a; mplier = b; valid_in = 1'b1; dest_ready = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        mcand = W'($urandom); mplier = W'($urandom);
        chk("src_ready_drop", src_ready, 1'b0);
        n = 1;
        while (!valid_out && n < 100) begin
            if (pulse && n == 5) begin
                mcand = 16'd7; mplier = 16'd7; valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        valid_in = 1'b0;
        chk("latency", n, W + 1);
        chk("result", product, exp);
        $display("txn %h x %h -> %h latency %0d", a, b, product, n);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", valid_out, 1'b1);
            chk("hold_product", product, exp);
        end
        dest_ready = 1'b1;
        @(negedge clk);
        dest_ready = 1'b0;
        chk("done_valid", valid_out, 1'b0);
        chk("done_idle", src_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int t;
        repeat (3) @(negedge clk);
        chk("rst_src_ready", src_ready, 1'b1);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_product", product, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        chk("model_3x5", ref_mul(16'd3, 16'd5), 32'h0000000F);
        run_txn(16'd3, 16'd5, 32'h0000000F, 0, 1'b0);
`ifdef MUL_SIGNED_EN
        run_txn(16'hFFFD, 16'h0007, 32'hFFFFFFEB, 0, 1'b0);
        run_txn(16'h8000, 16'h8000, 32'h40000000, 2, 1'b0);
        run_txn(16'h8000, 16'h0001, 32'hFFFF8000, 0, 1'b0);
`else
        run_txn(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5, 1'b0);
`endif
        run_txn(16'h0000, 16'h1234, 32'h00000000, 0, 1'b1);

        // Reset 8 cycles into an operation aborts it.
        mcand = 16'h00FF; mplier = 16'h0100; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_valid_out", valid_out, 1'b0);
        chk("abort_src_ready", src_ready, 1'b1);
        chk("abort_product", product, 32'h0);
        $display("reset mid-operation: valid_out %0b src_ready %0b product %h", valid_out, src_ready, product);
        @(negedge clk);
        reset = 1'b1;
        run_txn(16'd2, 16'd9, 32'h00000012, 0, 1'b0);

        // Back-to-back with valid_in and dest_ready tied high.
        @(negedge clk);
        dest_ready = 1'b1;
        valid_in = 1'b1;
        prev = -1;
        for (int k = 0; k < 10; k++) begin
            t = 0;
            mcand = W'($urandom); mplier = W'($urandom);
            while (!src_ready && t < 50) begin
                @(negedge clk);
                mcand = W'($urandom); mplier = W'($urandom);
                t++;
            end
            chk("b2b_accept_timeout", src_ready, 1'b1);
            if (prev >= 0) chk("b2b_interval", cyc - prev, 18);
            $display("b2b accept %0d: %h x %h expect %h", k, mcand, mplier, ref_mul(mcand, mplier));
            prev = cyc;
            @(negedge clk);
        end
        valid_in = 1'b0;
        repeat (20) @(negedge clk);
        dest_ready = 1'b0;
        chk("final_idle", src_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
